// File: rtl/aes_inv_mixcolumns_iter_pkg.sv
// aes_inv_mixcolumns_iter_pkg: FSM states and GF(2^8) helpers shared by the inverse MixColumns blocks.
package aes_inv_mixcolumns_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] GF_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_mixcolumn_word.sv
// aes_inv_mixcolumn_word: combinational InvMixColumns on one 32-bit column (row 0 = MSB byte).
module aes_inv_mixcolumn_word
    import aes_inv_mixcolumns_iter_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    // 9, 11, 13 and 14 are built from the x2/x4/x8 xtime chain of each byte
    for (genvar i = 0; i < 4; i++) begin : g_byte
        logic [7:0] a, x2, x4, x8;
        assign a     = col_in[31-8*i -: 8];
        assign x2    = xtime(a);
        assign x4    = xtime(x2);
        assign x8    = xtime(x4);
        assign m9[i] = x8 ^ a;
        assign mb[i] = x8 ^ x2 ^ a;
        assign md[i] = x8 ^ x4 ^ a;
        assign me[i] = x8 ^ x4 ^ x2;
    end

    for (genvar i = 0; i < 4; i++) begin : g_row
        assign col_out[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end

endmodule

// File: rtl/aes_inv_mixcolumns_iter.sv
// aes_inv_mixcolumns_iter: AddRoundKey then InvMixColumns, one column per clock,
// with valid/ready handshakes on both sides.
module aes_inv_mixcolumns_iter
    import aes_inv_mixcolumns_iter_pkg::*;
#(
    parameter int ADD_KEY = 1,
    parameter int COLS    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] round_key,
    input  logic         skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int CW = $clog2(COLS);
    localparam logic [CW-1:0] LAST = CW'(COLS - 1);

    state_t          state, next;
    logic [127:0]    state_reg;
    logic [CW-1:0]   col_cnt;
    logic [6:0]      base;
    logic [31:0]     col_in, col_out;

    assign base   = 7'd127 - {col_cnt, 5'd0};
    assign col_in = state_reg[base -: 32];

    aes_inv_mixcolumn_word u_word (
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_comb begin
        next = state;
        next = (state == IDLE) ? (in_valid ? (skip_mix ? DONE : COL) : IDLE) :
               (state == COL)  ? ((col_cnt == LAST) ? DONE : COL) :
               (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            state_reg <= '0;
            col_cnt   <= '0;
        end else begin
            state <= next;
            if (state == IDLE && in_valid) begin
                state_reg <= data_in ^ ((ADD_KEY != 0) ? round_key : 128'd0);
                col_cnt   <= '0;
            end else if (state == COL) begin
                state_reg[base -: 32] <= col_out;
                col_cnt               <= col_cnt + CW'(1);
            end
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == COL) || (state == DONE);
    assign data_out  = state_reg;

endmodule
